// File: rtl/wb_commit_buffer_if.sv
// rtl/wb_commit_buffer_if.sv - WB capture inputs and commit stream bundle for wb_commit_buffer
interface wb_commit_buffer_if;
    logic        WB_RegWrite_signal;
    logic [4:0]  WB_write_register;
    logic [31:0] WB_write_data;
    logic [2:0]  WB_exception_signal;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_reg;
    logic [31:0] out_data;
    logic [2:0]  out_exc;

    modport master (
        output WB_RegWrite_signal, WB_write_register, WB_write_data, WB_exception_signal,
        output out_ready,
        input  out_valid, out_reg, out_data, out_exc
    );

    modport slave (
        input  WB_RegWrite_signal, WB_write_register, WB_write_data, WB_exception_signal,
        input  out_ready,
        output out_valid, out_reg, out_data, out_exc
    );
endinterface

// File: rtl/wb_commit_buffer.sv
// rtl/wb_commit_buffer.sv - show-ahead commit FIFO behind the MIPS WB stage with debug counters
// Optional: COMMIT_EXC_HALT_EN freezes capture after the first buffered exception.
module wb_commit_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     SYS_clk,
    input  logic                     SYS_reset,
    wb_commit_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         commit_count,
    output logic [7:0]               drop_count,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [39:0]   head;

    logic push_req;
    logic capture_en;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    assign push_req = (bus.WB_RegWrite_signal && (bus.WB_write_register != 5'd0))
                    || (bus.WB_exception_signal != 3'd0);
`ifdef COMMIT_EXC_HALT_EN
    assign capture_en = push_req && !halted;
`else
    assign capture_en = push_req;
`endif
    assign pop     = (level != '0) && bus.out_ready;
    assign full    = (level == FULL_LEVEL);
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = capture_en && (!full || pop);
    assign drop    = capture_en && full && !pop;

    always_ff @(posedge SYS_clk) begin
        if (push_ok)
            mem[wr_ptr] <= {bus.WB_exception_signal, bus.WB_write_register, bus.WB_write_data};
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (commit_count != '1)
                    commit_count <= commit_count + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                level <= level + 1'b1;
            else if (pop && !push_ok)
                level <= level - 1'b1;
            if (drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 1'b1;
        end
    end

`ifdef COMMIT_EXC_HALT_EN
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset)
            halted <= 1'b0;
        else if (push_ok && (bus.WB_exception_signal != 3'd0))
            halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

    assign head          = mem[rd_ptr];
    assign bus.out_valid = (level != '0);
    assign bus.out_exc   = bus.out_valid ? head[39:37] : 3'd0;
    assign bus.out_reg   = bus.out_valid ? head[36:32] : 5'd0;
    assign bus.out_data  = bus.out_valid ? head[31:0]  : 32'd0;
endmodule

// File: tb/tb_wb_commit_buffer.sv
// tb/tb_wb_commit_buffer.sv - self-checking bench for wb_commit_buffer (table, directed and random)
module tb_wb_commit_buffer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef COMMIT_EXC_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  level;
    logic [15:0] commit_count;
    logic [7:0]  drop_count;
    logic        halted;

    always #5 clk = ~clk;

    wb_commit_buffer_if bus ();

    wb_commit_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .SYS_clk      (clk),
        .SYS_reset    (rst_n),
        .bus          (bus),
        .level        (level),
        .commit_count (commit_count),
        .drop_count   (drop_count),
        .halted       (halted)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [39:0] mq[$];
    int          m_commit;
    int          m_drop;
    bit          m_halt;

    typedef struct {
        logic        rw;
        logic [4:0]  rg;
        logic [31:0] d;
        logic        rdy;
        int          e_level;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        int          e_commit;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic model_clear();
        mq.delete();
        m_commit = 0;
        m_drop   = 0;
        m_halt   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the reference model, then sample 1 time unit after the edge.
    task automatic cyc(input logic rw, input logic [4:0] rg, input logic [31:0] d,
                       input logic [2:0] ex, input logic rdy);
        bit          req;
        bit          cap;
        logic [39:0] tmp;
        bus.WB_RegWrite_signal  = rw;
        bus.WB_write_register   = rg;
        bus.WB_write_data       = d;
        bus.WB_exception_signal = ex;
        bus.out_ready           = rdy;
        req = (rw && rg != 5'd0) || (ex != 3'd0);
        cap = req && !(HALT_EN && m_halt);
        if (mq.size() > 0 && rdy) tmp = mq.pop_front();
        if (cap) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({ex, rg, d});
                if (m_commit < 65535) m_commit++;
                if (ex != 3'd0 && HALT_EN) m_halt = 1'b1;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 5'd0, 32'd0, 3'd0, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.WB_RegWrite_signal  = 1'b0;
        bus.WB_write_register   = 5'd0;
        bus.WB_write_data       = 32'd0;
        bus.WB_exception_signal = 3'd0;
        bus.out_ready           = 1'b0;
        model_clear();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string name);
        logic [39:0] h;
        h = (mq.size() > 0) ? mq[0] : 40'd0;
        chk({name, ".level"},  64'(level),         64'(mq.size()));
        chk({name, ".valid"},  64'(bus.out_valid), 64'(mq.size() > 0));
        chk({name, ".head"},   64'({bus.out_exc, bus.out_reg, bus.out_data}), 64'(h));
        chk({name, ".commit"}, 64'(commit_count),  64'(m_commit));
        chk({name, ".drop"},   64'(drop_count),    64'(m_drop));
        chk({name, ".halted"}, 64'(halted),        64'(m_halt));
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd8, 32'h11, 1'b0, 1, 5'd8, 32'h11, 1};
        tbl[1] = '{1'b1, 5'd9, 32'h22, 1'b0, 2, 5'd8, 32'h11, 2};
        tbl[2] = '{1'b1, 5'd0, 32'h33, 1'b0, 2, 5'd8, 32'h11, 2};
        tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b1, 1, 5'd9, 32'h22, 2};
        tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b1, 0, 5'd0, 32'h0,  2};

        do_reset();
        chk("rst.level",  64'(level),         64'd0);
        chk("rst.valid",  64'(bus.out_valid), 64'd0);
        chk("rst.commit", 64'(commit_count),  64'd0);
        chk("rst.drop",   64'(drop_count),    64'd0);
        chk("rst.halted", 64'(halted),        64'd0);
        chk("rst.data",   64'(bus.out_data),  64'd0);

        for (int i = 0; i < 5; i++) begin
            cyc(tbl[i].rw, tbl[i].rg, tbl[i].d, 3'd0, tbl[i].rdy);
            chk($sformatf("tbl%0d.level", i),  64'(level),        64'(tbl[i].e_level));
            chk($sformatf("tbl%0d.reg", i),    64'(bus.out_reg),  64'(tbl[i].e_reg));
            chk($sformatf("tbl%0d.data", i),   64'(bus.out_data), 64'(tbl[i].e_data));
            chk($sformatf("tbl%0d.commit", i), 64'(commit_count), 64'(tbl[i].e_commit));
        end

        // Overfill: 10 pushes into 8 slots.
        do_reset();
        for (int i = 1; i <= 10; i++) cyc(1'b1, 5'(i), 32'h100 + 32'(i), 3'd0, 1'b0);
        chk("fill.level",  64'(level),        64'd8);
        chk("fill.drop",   64'(drop_count),   64'd2);
        chk("fill.commit", 64'(commit_count), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d.reg", i),  64'(bus.out_reg),  64'(i));
            chk($sformatf("drain%0d.data", i), 64'(bus.out_data), 64'(32'h100 + 32'(i)));
            idle(1'b1);
        end
        chk("drain.valid", 64'(bus.out_valid), 64'd0);
        chk("drain.reg",   64'(bus.out_reg),   64'd0);
        chk("drain.data",  64'(bus.out_data),  64'd0);
        chk("drain.exc",   64'(bus.out_exc),   64'd0);

        // Full with simultaneous pop and push.
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 5'(i), 32'(i), 3'd0, 1'b0);
        cyc(1'b1, 5'd10, 32'hAA, 3'd0, 1'b1);
        chk("fullpp.level", 64'(level),      64'd8);
        chk("fullpp.drop",  64'(drop_count), 64'd0);
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("fullpp%0d.reg", i), 64'(bus.out_reg), 64'(i));
            idle(1'b1);
        end
        chk("fullpp.last.reg",  64'(bus.out_reg),  64'd10);
        chk("fullpp.last.data", 64'(bus.out_data), 64'hAA);
        idle(1'b1);
        chk("fullpp.empty", 64'(bus.out_valid), 64'd0);

        // Streaming one in, one out for 20 cycles wraps the pointers.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 5'(1 + (i % 31)), 32'hC000 + 32'(i), 3'd0, 1'b1);
            chk($sformatf("stream%0d.level", i), 64'(level),        64'd1);
            chk($sformatf("stream%0d.data", i),  64'(bus.out_data), 64'(32'hC000 + 32'(i)));
        end
        chk("stream.drop", 64'(drop_count), 64'd0);

        // Exception entry followed by a normal write.
        do_reset();
        cyc(1'b0, 5'd0, 32'd0, 3'd3, 1'b0);
        cyc(1'b1, 5'd5, 32'h55, 3'd0, 1'b0);
        chk("exc.head_exc", 64'(bus.out_exc), 64'd3);
        chk("exc.level",  64'(level),        HALT_EN ? 64'd1 : 64'd2);
        chk("exc.commit", 64'(commit_count), HALT_EN ? 64'd1 : 64'd2);
        chk("exc.halted", 64'(halted),       HALT_EN ? 64'd1 : 64'd0);

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 5'(i), 32'(i), 3'd0, 1'b0);
        chk("mid.level",  64'(level),        64'd5);
        chk("mid.commit", 64'(commit_count), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.level",  64'(level),         64'd0);
        chk("arst.valid",  64'(bus.out_valid), 64'd0);
        chk("arst.commit", 64'(commit_count),  64'd0);
        chk("arst.drop",   64'(drop_count),    64'd0);
        chk("arst.data",   64'(bus.out_data),  64'd0);
        do_reset();

        // Randomized traffic against the queue model, three batches.
        for (int b = 0; b < 3; b++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                logic [2:0] ex;
                ex = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                cyc(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    $urandom, ex,
                    ($urandom_range(0, 99) < (b == 0 ? 30 : (b == 1 ? 60 : 90))) ? 1'b1 : 1'b0);
                check_model($sformatf("rnd%0d_%0d", b, c));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
